fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the single write port of one `fifo` instance between N_REQ producers.
- Round-robin arbitration, with an optional per-requester lock for bursts of up to MAX_BURST consecutive writes.
- Sits between the producers (UART RX, core event queue, etc.) and the fifo's i_wr/i_data/o_full.
- Handshake is same-cycle: a producer sees o_ack[k] in the cycle its byte is written, and advances its data on that edge.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- DATA_SZ, 8, data width; must match the fifo data width.
- MAX_BURST, 4, maximum consecutive transfers granted to one locked requester; legal range 1..255.
- IDX_SZ, $clog2(N_REQ), requester index width (derived; do not override).

Ports:
- i_clk  input  1  system clock; all state updates on posedge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req  input  N_REQ  requester k has valid data on its data slice.
- i_lock  input  N_REQ  requester k wants to keep the grant after its current transfer.
- i_data  input  N_REQ*DATA_SZ  requester k's data in bits [k*DATA_SZ +: DATA_SZ].
- o_ack  output  N_REQ  one-hot; requester k's data is written this cycle.
- o_wr  output  1  to fifo i_wr.
- o_data  output  DATA_SZ  to fifo i_data; selected requester's slice.
- i_full  input  1  from fifo o_full.
- o_owner  output  IDX_SZ  index of the most recently granted requester (registered).
- o_busy  output  1  arbiter is in LOCKED state (registered).

Behaviour:
- Registered state:
  - state: IDLE or LOCKED.
  - rr_ptr (IDX_SZ): highest-priority index.
  - owner (IDX_SZ).
  - burst_cnt (8 bit).
- Reset (i_rst_n=0, asynchronous):
  - state=IDLE, rr_ptr=0, owner=0, burst_cnt=0, o_owner=0, o_busy=0.
  - o_wr=0, o_ack=0 and o_data=0 while reset is asserted; combinational outputs are gated by i_rst_n.
- Selection is combinational; zero latency from i_req to o_wr.
  - IDLE: sel = first k with i_req[k]=1, scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - LOCKED: sel = owner, and only if i_req[owner]=1; all other requesters are ignored.
- Transfer condition: xfer = sel_valid & !i_full.
  - When xfer: o_wr=1, o_ack[sel]=1, o_data=i_data slice of sel.
  - Otherwise: o_wr=0, o_ack=0, o_data=0.
- Full: with i_full=1 there is never a write or ack, and no state changes. A requester waiting on a full fifo keeps its priority position.
- IDLE, on xfer:
  - rr_ptr <= (sel+1) mod N_REQ; owner <= sel; o_owner <= sel.
  - If i_lock[sel]=1 and MAX_BURST>1: state <= LOCKED, burst_cnt <= 1.
  - Otherwise stay IDLE.
- LOCKED, on xfer:
  - burst_cnt <= burst_cnt+1.
  - If i_lock[owner]=0, or burst_cnt+1 == MAX_BURST: state <= IDLE, burst_cnt <= 0.
  - rr_ptr was already advanced past owner when the lock began; it is not changed during LOCKED.
- LOCKED with i_req[owner]=0: no transfer that cycle; state <= IDLE, burst_cnt <= 0 at the next edge. Other requesters become eligible one cycle later.
- LOCKED with i_full=1: hold LOCKED and burst_cnt unchanged. Full stalls never count toward MAX_BURST.
- No requests: o_wr=0, state unchanged.
- A reset asserted mid-burst returns the block to IDLE immediately. Producers must treat unacked data as not sent.
- Modulo wrap for non-power-of-2 N_REQ: index N_REQ-1 wraps to 0, never to N_REQ.
- o_busy equals (state==LOCKED), registered.

Test Plan:
- Reset, then i_req=4'b1111, i_lock=0, i_full=0, data k = 8'h40+k → writes 40,41,42,43,40,... with o_ack cycling 0001,0010,0100,1000. One write per cycle.
- i_req=4'b1010 from rr_ptr=0 → grants 1,3,1,3. Then drop req3 → req1 granted on consecutive cycles.
- i_lock[2]=1, i_req=4'b1111, MAX_BURST=4, rr_ptr=2 → exactly four consecutive acks to requester 2 with o_busy=1 during cycles 2–4. Then IDLE, and next grant is requester 3.
- Locked burst on requester 0 with i_full=1 for 3 cycles mid-burst → no o_wr/o_ack during the stall. burst_cnt holds, burst resumes and totals 4 writes.
- Locked owner drops i_req after 2 transfers → one idle cycle, o_busy falls, next cycle the round-robin winner is granted.
- Assert i_rst_n=0 asynchronously mid-burst → o_wr, o_ack and o_busy go 0 without waiting for a clock edge. After release, first grant is requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among N_REQ producers,
// with an optional per-requester lock that keeps the grant for short bursts.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_SZ   = 8,
    parameter int MAX_BURST = 4,
    parameter int IDX_SZ    = $clog2(N_REQ)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ-1:0]           i_lock,
    input  logic [N_REQ*DATA_SZ-1:0]   i_data,
    output logic [N_REQ-1:0]           o_ack,
    output logic                       o_wr,
    output logic [DATA_SZ-1:0]         o_data,
    input  logic                       i_full,
    output logic [IDX_SZ-1:0]          o_owner,
    output logic                       o_busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_SZ-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_SZ-1:0]   owner_q, owner_d;
    logic [7:0]          burst_cnt_q, burst_cnt_d;

    logic [IDX_SZ-1:0]   sel;
    logic                sel_valid;
    logic                xfer;
    logic [IDX_SZ-1:0]   sel_inc;
    logic [DATA_SZ-1:0]  data_sel;
    int                  idx;

    // Selection: a locked owner excludes everyone else; otherwise scan from rr_ptr.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        idx       = 0;
        if (state_q == LOCKED) begin
            sel       = owner_q;
            sel_valid = i_req[owner_q];
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                idx = (int'(rr_ptr_q) + i) % N_REQ;
                if (!sel_valid && i_req[idx]) begin
                    sel       = IDX_SZ'(idx);
                    sel_valid = 1'b1;
                end
            end
        end
    end

    assign xfer    = sel_valid && !i_full;
    assign sel_inc = (sel == IDX_SZ'(N_REQ - 1)) ? '0 : sel + IDX_SZ'(1);

    always_comb begin
        data_sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (sel == IDX_SZ'(k)) begin
                data_sel = i_data[k*DATA_SZ +: DATA_SZ];
            end
        end
    end

    // Outputs are forced low while reset is held, independent of the clock.
    always_comb begin
        o_wr   = 1'b0;
        o_ack  = '0;
        o_data = '0;
        if (xfer && i_rst_n) begin
            o_wr   = 1'b1;
            o_ack  = N_REQ'(1) << sel;
            o_data = data_sel;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    rr_ptr_d = sel_inc;
                    owner_d  = sel;
                    if (i_lock[sel] && (MAX_BURST > 1)) begin
                        state_d     = LOCKED;
                        burst_cnt_d = 8'd1;
                    end
                end
            end
            LOCKED: begin
                // A full fifo freezes the burst; it never counts toward MAX_BURST.
                if (!i_full) begin
                    if (!i_req[owner_q]) begin
                        state_d     = IDLE;
                        burst_cnt_d = '0;
                    end else if (!i_lock[owner_q] ||
                                 (burst_cnt_q + 8'd1 == 8'(MAX_BURST))) begin
                        state_d     = IDLE;
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign o_owner = owner_q;
    assign o_busy  = (state_q == LOCKED);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed table-driven bench for fifo_wr_arbiter (N_REQ=4, MAX_BURST=4).
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] data_in;
    logic [3:0]  ack;
    logic        wr;
    logic [7:0]  dout;
    logic        full;
    logic [1:0]  owner;
    logic        busy;

    int total = 0;
    int bad   = 0;

    fifo_wr_arbiter #(
        .N_REQ(4),
        .DATA_SZ(8),
        .MAX_BURST(4)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_req(req),
        .i_lock(lock),
        .i_data(data_in),
        .o_ack(ack),
        .o_wr(wr),
        .o_data(dout),
        .i_full(full),
        .o_owner(owner),
        .o_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic       full;
        logic [3:0] ack;
        logic [7:0] data;
        logic [1:0] owner;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] r, input logic [3:0] l, input logic f,
                       input logic [3:0] a, input logic [7:0] d,
                       input logic [1:0] o, input logic b);
        vec_t v;
        v.req = r; v.lock = l; v.full = f; v.ack = a; v.data = d;
        v.owner = o; v.busy = b;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    initial begin
        data_in = {8'h43, 8'h42, 8'h41, 8'h40};
        req  = 4'b1111;
        lock = 4'b0000;
        full = 1'b0;
        rst_n = 1'b0;

        // reset state with requests present: outputs must stay quiet
        #2;
        check("rst_wr",    -1, 32'(wr),    32'd0);
        check("rst_ack",   -1, 32'(ack),   32'd0);
        check("rst_data",  -1, 32'(dout),  32'd0);
        check("rst_busy",  -1, 32'(busy),  32'd0);
        check("rst_owner", -1, 32'(owner), 32'd0);
        #10;
        rst_n = 1'b1;

        // plain round robin, all requesting
        add(4'b1111, 4'b0000, 0, 4'b0001, 8'h40, 2'd0, 0);
        add(4'b1111, 4'b0000, 0, 4'b0010, 8'h41, 2'd0, 0);
        add(4'b1111, 4'b0000, 0, 4'b0100, 8'h42, 2'd1, 0);
        add(4'b1111, 4'b0000, 0, 4'b1000, 8'h43, 2'd2, 0);
        add(4'b1111, 4'b0000, 0, 4'b0001, 8'h40, 2'd3, 0);
        // sparse requests 1 and 3, then only 1
        add(4'b1010, 4'b0000, 0, 4'b0010, 8'h41, 2'd0, 0);
        add(4'b1010, 4'b0000, 0, 4'b1000, 8'h43, 2'd1, 0);
        add(4'b1010, 4'b0000, 0, 4'b0010, 8'h41, 2'd3, 0);
        add(4'b1010, 4'b0000, 0, 4'b1000, 8'h43, 2'd1, 0);
        add(4'b0010, 4'b0000, 0, 4'b0010, 8'h41, 2'd3, 0);
        add(4'b0010, 4'b0000, 0, 4'b0010, 8'h41, 2'd1, 0);
        // locked burst on requester 2 limited to 4, then 3 wins
        add(4'b1111, 4'b0100, 0, 4'b0100, 8'h42, 2'd1, 0);
        add(4'b1111, 4'b0100, 0, 4'b0100, 8'h42, 2'd2, 1);
        add(4'b1111, 4'b0100, 0, 4'b0100, 8'h42, 2'd2, 1);
        add(4'b1111, 4'b0100, 0, 4'b0100, 8'h42, 2'd2, 1);
        add(4'b1111, 4'b0100, 0, 4'b1000, 8'h43, 2'd2, 0);
        // locked burst on requester 0 with a 3-cycle full stall
        add(4'b0001, 4'b0001, 0, 4'b0001, 8'h40, 2'd3, 0);
        add(4'b0001, 4'b0001, 0, 4'b0001, 8'h40, 2'd0, 1);
        add(4'b0001, 4'b0001, 1, 4'b0000, 8'h00, 2'd0, 1);
        add(4'b0001, 4'b0001, 1, 4'b0000, 8'h00, 2'd0, 1);
        add(4'b0001, 4'b0001, 1, 4'b0000, 8'h00, 2'd0, 1);
        add(4'b0001, 4'b0001, 0, 4'b0001, 8'h40, 2'd0, 1);
        add(4'b0001, 4'b0001, 0, 4'b0001, 8'h40, 2'd0, 1);
        add(4'b0001, 4'b0000, 0, 4'b0001, 8'h40, 2'd0, 0);
        // locked owner 1 drops its request after two transfers
        add(4'b1111, 4'b0010, 0, 4'b0010, 8'h41, 2'd0, 0);
        add(4'b1111, 4'b0010, 0, 4'b0010, 8'h41, 2'd1, 1);
        add(4'b1101, 4'b0010, 0, 4'b0000, 8'h00, 2'd1, 1);
        add(4'b1101, 4'b0000, 0, 4'b0100, 8'h42, 2'd1, 0);

        foreach (vecs[i]) begin
            req  = vecs[i].req;
            lock = vecs[i].lock;
            full = vecs[i].full;
            #2;
            check("wr",    i, 32'(wr),    32'(|vecs[i].ack));
            check("ack",   i, 32'(ack),   32'(vecs[i].ack));
            check("data",  i, 32'(dout),  32'(vecs[i].data));
            check("owner", i, 32'(owner), 32'(vecs[i].owner));
            check("busy",  i, 32'(busy),  32'(vecs[i].busy));
            @(posedge clk);
            #1;
        end

        // asynchronous reset in the middle of a burst on requester 3 (rr_ptr=3)
        req  = 4'b1111;
        lock = 4'b1000;
        full = 1'b0;
        #2;
        check("ar_first_ack", 0, 32'(ack), 32'h8);
        @(posedge clk);
        #1;
        #2;
        check("ar_locked_busy", 0, 32'(busy), 32'd1);
        check("ar_locked_ack",  0, 32'(ack),  32'h8);
        rst_n = 1'b0;
        #1;
        check("ar_wr",    0, 32'(wr),    32'd0);
        check("ar_ack",   0, 32'(ack),   32'd0);
        check("ar_data",  0, 32'(dout),  32'd0);
        check("ar_busy",  0, 32'(busy),  32'd0);
        check("ar_owner", 0, 32'(owner), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lock  = 4'b0000;
        #1;
        check("ar_post_ack",  0, 32'(ack),  32'h1);
        check("ar_post_data", 0, 32'(dout), 32'h40);
        @(posedge clk);
        #1;
        check("ar_post_owner", 0, 32'(owner), 32'd0);
        check("ar_post_busy",  0, 32'(busy),  32'd0);
        check("ar_next_ack",   0, 32'(ack),   32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
